// File: rtl/mips_loader_pkg.sv
// Shared types and defaults for the MIPS program loader.
package mips_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned MAX_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; the word and its strobe
// are registered so they can drive the memory write port directly.
module byte_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q;
  logic [31:0] sh_q;
  logic        wv_q;

  // Byte index, shift register and one-cycle word strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      sh_q  <= '0;
      wv_q  <= 1'b0;
    end else if (clr_i) begin
      idx_q <= '0;
      sh_q  <= '0;
      wv_q  <= 1'b0;
    end else begin
      wv_q <= byte_valid_i && (idx_q == 2'd3);
      if (byte_valid_i) begin
        idx_q <= idx_q + 2'd1;
        sh_q  <= {sh_q[23:0], byte_i};
      end
    end
  end

  // Next accepted byte completes a word.
  always_comb begin
    last_byte_o = (idx_q == 2'd3);
  end

  assign word_valid_o = wv_q;
  assign word_o       = sh_q;

endmodule

// File: rtl/mips_program_loader.sv
// Framed byte-stream boot loader: SYNC, LEN_HI, LEN_LO, 4N payload bytes, CHK.
// Writes big-endian words to sequential addresses and releases the core only
// after a frame whose XOR checksum matches.
module mips_program_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [10:0]       word_cnt
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          chk_q, chk_d;
  logic [10:0]         wcnt_q, wcnt_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rdy_q;

  logic                xfer;
  logic [15:0]         len_rx;
  logic                len_bad;
  logic                pk_clr;
  logic                pk_valid;
  logic                pk_last;

  assign xfer    = in_valid && rdy_q;
  assign len_rx  = {len_hi_q, in_data};
  assign len_bad = (len_rx == '0) || ({1'b0, len_rx} > MAX_LEN);

  byte_word_packer u_packer (
    .clk_i        (clk1),
    .rst_i        (reset),
    .clr_i        (pk_clr),
    .byte_valid_i (pk_valid),
    .byte_i       (in_data),
    .last_byte_o  (pk_last),
    .word_valid_o (mem_we),
    .word_o       (mem_wdata)
  );

  // State, length, checksum, address and status registers.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_hi_q   <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      chk_q      <= '0;
      wcnt_q     <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      chk_q      <= chk_d;
      wcnt_q     <= wcnt_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdy_q      <= 1'b1;
    end
  end

  // Frame parser: next state, datapath updates and packer control.
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    n_d        = n_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    chk_d      = chk_q;
    wcnt_d     = wcnt_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    pk_clr     = 1'b0;
    pk_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer && (in_data == SYNC_BYTE)) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            n_d     = len_rx;
            addr_d  = '0;
            chk_d   = '0;
            wcnt_d  = '0;
            pk_clr  = 1'b1;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          pk_valid = 1'b1;
          chk_d    = chk_q ^ in_data;
          if (pk_last) begin
            mem_addr_d = addr_q;
            addr_d     = addr_q + ADDR_W'(1);
            wcnt_d     = wcnt_q + 11'd1;
            if (({5'b0, wcnt_q} + 16'd1) == n_q) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (in_data == chk_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          state_d = S_LEN_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = rdy_q;
  assign mem_addr = mem_addr_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;
  assign word_cnt = wcnt_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Bench for mips_program_loader: frame-level model of expected writes and
// status changes, checked every cycle, plus literal expectations per scenario.
module tb_mips_program_loader;

  logic        clk1 = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [10:0] word_cnt;

  mips_program_loader #(
    .ADDR_W    (10),
    .MAX_WORDS (1024),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk1      (clk1),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  always #5 clk1 = ~clk1;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected events, stamped with the negedge index at which they become visible.
  localparam logic [1:0] K_WR = 2'd0, K_ST = 2'd1, K_WC0 = 2'd2;
  typedef struct packed {
    int unsigned idx;
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t          evq[$];
  int unsigned  negcnt = 0;
  logic         m_done = 1'b0, m_err = 1'b0, m_hold = 1'b1, m_rdy = 1'b0;
  int unsigned  m_wcnt = 0;
  int unsigned  wr_seen = 0;
  logic [31:0]  obs_addr[$];
  logic [31:0]  obs_data[$];
  int unsigned  obs_time[$];
  logic [31:0]  pw[$];
  logic [7:0]   last_x;

  // Readiness follows reset: low while held, high from the first edge after.
  always @(posedge clk1 or posedge reset) begin
    if (reset) m_rdy <= 1'b0;
    else       m_rdy <= 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk1) begin : cmp
    ev_t         ev;
    logic        exp_we;
    logic [31:0] exp_a, exp_d;
    negcnt++;
    if (reset) begin
      evq.delete();
      m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1; m_wcnt = 0;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    end else begin
      exp_we = 1'b0; exp_a = '0; exp_d = '0;
      while (evq.size() > 0 && evq[0].idx <= negcnt) begin
        ev = evq.pop_front();
        case (ev.kind)
          K_WR:    begin exp_we = 1'b1; exp_a = ev.a; exp_d = ev.d; m_wcnt++; end
          K_ST:    begin m_done = ev.d[2]; m_err = ev.d[1]; m_hold = ev.d[0]; end
          default: m_wcnt = 0;
        endcase
      end
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
        chk("mem_addr", 32'(mem_addr), exp_a);
        chk("mem_wdata", mem_wdata, exp_d);
      end
      if (mem_we) begin
        wr_seen++;
        obs_addr.push_back(32'(mem_addr));
        obs_data.push_back(mem_wdata);
        obs_time.push_back(negcnt);
      end
      chk("word_cnt", 32'(word_cnt), m_wcnt);
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
    end
  end

  // Drive one byte (after optional idle cycles); returns the negedge index
  // at which its effect must first be visible. Entered/left at posedge+1.
  task automatic send(input logic [7:0] b, input int unsigned gap, output int unsigned eidx);
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk1); #1; end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk1);
    eidx = negcnt + 1;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input int unsigned idx, input logic [1:0] kind, input logic [31:0] a, input logic [31:0] d);
    ev_t ev;
    ev.idx = idx; ev.kind = kind; ev.a = a; ev.d = d;
    evq.push_back(ev);
  endtask

  function automatic int unsigned gapn(input bit gaps);
    return gaps ? $urandom_range(0, 3) : 0;
  endfunction

  // Send a frame carrying words pw[]; stop_after>0 truncates the payload.
  task automatic frame(input logic [7:0] hi, input logic [7:0] lo, input bit gaps,
                       input bit use_chk, input logic [7:0] chk_byte, input int unsigned stop_after);
    int unsigned e, n, sent;
    logic [7:0]  x, byt, c;
    logic [31:0] w;
    x = 8'h00; sent = 0;
    n = {16'd0, hi, lo};
    send(8'hA5, gapn(gaps), e); push(e, K_ST, 0, 32'b001);
    send(hi, gapn(gaps), e);
    send(lo, gapn(gaps), e);
    if (n == 0 || n > 1024) begin
      push(e, K_ST, 0, 32'b011);
      return;
    end
    push(e, K_WC0, 0, 0);
    for (int unsigned i = 0; i < n; i++) begin
      w = pw[i];
      for (int unsigned b = 0; b < 4; b++) begin
        byt = 8'(w >> (24 - 8 * b));
        x ^= byt;
        send(byt, gapn(gaps), e);
        sent++;
        if (b == 3) push(e, K_WR, i % 1024, w);
        if (stop_after != 0 && sent == stop_after) return;
      end
    end
    last_x = x;
    c = use_chk ? chk_byte : x;
    send(c, gapn(gaps), e);
    push(e, K_ST, 0, (c == x) ? 32'b100 : 32'b011);
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk1); #1; end
  endtask

  initial begin : main
    int unsigned e, base, bad_gap;
    reset = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    chk("lit_rst_in_ready", 32'(in_ready), 32'd0);
    chk("lit_rst_hold", 32'(cpu_hold), 32'd1);
    chk("lit_rst_wcnt", 32'(word_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clk1); #1;
    chk("lit_ready_after_rst", 32'(in_ready), 32'd1);

    // Noise before sync, then the two-word good frame (its bytes XOR to 00).
    send(8'h00, 0, e); send(8'hFF, 0, e); send(8'h11, 0, e);
    pw = '{32'h12345678, 32'h9ABCDEF0};
    base = wr_seen;
    frame(8'h00, 8'h02, 1'b0, 1'b0, 8'h00, 0);
    idle(3);
    chk("lit_xsum", 32'(last_x), 32'h00);
    chk("lit_good_done", 32'(done), 32'd1);
    chk("lit_good_hold", 32'(cpu_hold), 32'd0);
    chk("lit_good_wcnt", 32'(word_cnt), 32'd2);
    chk("lit_good_nwr", wr_seen - base, 32'd2);
    chk("lit_good_a0", obs_addr[base], 32'd0);
    chk("lit_good_d0", obs_data[base], 32'h12345678);
    chk("lit_good_a1", obs_addr[base + 1], 32'd1);
    chk("lit_good_d1", obs_data[base + 1], 32'h9ABCDEF0);

    // Restart from DONE with a wrong checksum.
    base = wr_seen;
    frame(8'h00, 8'h02, 1'b0, 1'b1, 8'h08, 0);
    idle(3);
    chk("lit_bad_err", 32'(err), 32'd1);
    chk("lit_bad_done", 32'(done), 32'd0);
    chk("lit_bad_hold", 32'(cpu_hold), 32'd1);
    chk("lit_bad_nwr", wr_seen - base, 32'd2);

    // Illegal lengths: zero and MAX_WORDS+1.
    base = wr_seen;
    frame(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
    idle(3);
    chk("lit_len0_err", 32'(err), 32'd1);
    frame(8'h04, 8'h01, 1'b0, 1'b0, 8'h00, 0);
    idle(3);
    chk("lit_len1025_err", 32'(err), 32'd1);
    chk("lit_badlen_nwr", wr_seen - base, 32'd0);

    // Good frame with random valid gaps.
    base = wr_seen;
    frame(8'h00, 8'h02, 1'b1, 1'b0, 8'h00, 0);
    idle(3);
    chk("lit_gap_done", 32'(done), 32'd1);
    chk("lit_gap_a1", obs_addr[base + 1], 32'd1);
    chk("lit_gap_d1", obs_data[base + 1], 32'h9ABCDEF0);

    // Reset after six payload bytes.
    base = wr_seen;
    frame(8'h00, 8'h02, 1'b0, 1'b0, 8'h00, 6);
    idle(2);
    chk("lit_partial_nwr", wr_seen - base, 32'd1);
    reset = 1'b1;
    @(negedge clk1);
    chk("lit_mid_rst_done", 32'(done), 32'd0);
    chk("lit_mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("lit_mid_rst_wcnt", 32'(word_cnt), 32'd0);
    @(posedge clk1); #1;
    reset = 1'b0;
    @(posedge clk1); #1;

    // Full frame after reset.
    frame(8'h00, 8'h02, 1'b0, 1'b0, 8'h00, 0);
    idle(3);
    chk("lit_reload_done", 32'(done), 32'd1);

    // Maximum frame back-to-back; word 0 starts with the sync value.
    pw.delete();
    for (int unsigned i = 0; i < 1024; i++) pw.push_back((i * 32'h9E3779B1) ^ 32'hA5000000);
    base = wr_seen;
    frame(8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 0);
    idle(3);
    chk("lit_max_done", 32'(done), 32'd1);
    chk("lit_max_wcnt", 32'(word_cnt), 32'd1024);
    chk("lit_max_nwr", wr_seen - base, 32'd1024);
    chk("lit_max_last_addr", obs_addr[obs_addr.size() - 1], 32'd1023);
    bad_gap = 0;
    for (int unsigned i = base + 1; i < wr_seen; i++)
      if (obs_time[i] - obs_time[i - 1] != 4) bad_gap++;
    chk("lit_max_spacing", bad_gap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
